adder_mp_seq: RTL and testbench
===============================

Name: adder_mp_seq

Overview:
Multi-precision add/subtract sequencer. It reuses one 8-bit ripple adder (adder_8b) byte-serially to add or subtract two WORDS-byte operands, LSB byte first, and chains the carry between bytes in a register. It sits between a requesting datapath or controller and the shared adder_8b. Operands and results use a start/busy/done handshake.

Parameters:
WORDS, 4, number of 8-bit bytes per operand (operand width = 8*WORDS); legal range 2..16.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request pulse; sampled only in IDLE or DONE
sub  input  1  0 = a+b+ci, 1 = a-b (two's complement; ci ignored)
ci  input  1  carry-in for add
a  input  8*WORDS  operand A, captured on accepted start
b  input  8*WORDS  operand B, captured on accepted start
s  output  8*WORDS  result
co  output  1  final carry-out (subtract: 1 = no borrow)
ovf  output  1  signed overflow of full-width result
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, result valid

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All registers update on the rising edge of clk.
- Reset: state=IDLE; s=0, co=0, ovf=0, busy=0, done=0; byte index=0; carry reg=0. Reset takes priority over all other inputs, including mid-RUN. A reset mid-operation discards the partial result with no done pulse.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: start=1 at an edge accepts the request and moves to RUN.
  - a is latched.
  - b is latched, inverted when sub=1.
  - carry reg = sub ? 1 : ci.
  - idx=0.
  - start=0 stays in IDLE.
- RUN: busy=1.
  - Each edge writes adder sum into s[8*idx +: 8] and loads carry reg from the adder carry-out.
  - idx increments each edge.
  - At the edge processing idx=WORDS-1, the final carry-out goes to co and ovf is computed. Then state moves to DONE.
  - start during RUN is ignored; operand inputs are not re-sampled.
- Adder operands are driven as: a_byte = a_lat[8*idx +: 8], b_byte = b_lat[8*idx +: 8], adder ci = carry reg.
- ovf = (a_msb == b_eff_msb) && (s_msb != a_msb), using the MSB byte operands and result, where b_eff_msb is the MSB of the (possibly inverted) latched b.
- DONE: done=1 for exactly one cycle, busy=0.
  - Next edge returns to IDLE, or goes directly to RUN if start=1 (back-to-back accept, same latch rules as IDLE).
- Latency: done is high in the cycle following WORDS+1 edges, counted from and including the accepting edge. Throughput is one op per WORDS+1 cycles.
- s holds its value after DONE until the next accepted start. It updates byte-wise during RUN, so s is only valid while done=1 or later in IDLE.
- co and ovf are held from DONE until the next operation's final byte.
- Width rules: internal carry is 1 bit; the result wraps modulo 2^(8*WORDS), with the carry reported on co.

Decomposition:
- Shared include header (adder_pkg.vh):
  - state localparams ST_IDLE=0, ST_RUN=1, ST_DONE=2.
  - BYTE_W=8.
- One sub-module: the existing adder_8b, instantiated once.
- Sequencing FSM, idx counter, operand/result registers stay in adder_mp_seq. No further split is needed.

Test Plan:
All scenarios use WORDS=4; the done pulse is checked at edge 5 after the accepting edge.
1. add a=0x000000FF, b=0x00000001, ci=0 -> s=0x00000100, co=0, ovf=0; busy high for 4 cycles, done exactly 1 cycle.
2. add a=0xFFFFFFFF, b=0x00000001, ci=0 -> s=0x00000000, co=1, ovf=0. Then with ci=1, a=0, b=0 -> s=0x00000001, co=0.
3. add a=0x7FFFFFFF, b=0x00000001 -> s=0x80000000, co=0, ovf=1. Then sub a=0x80000000, b=0x00000001 -> s=0x7FFFFFFF, co=1, ovf=1.
4. sub a=0x00000005, b=0x00000007, ci=1 (ignored) -> s=0xFFFFFFFE, co=0 (borrow), ovf=0.
5. start add 0x00000010+0x00000020, then re-pulse start with a=0xFFFFFFFF during RUN -> ignored, s=0x00000030. Then start held high in DONE with 0x00000001+0x00000001 -> accepted with no IDLE cycle, s=0x00000002 after 5 more edges.
6. start add 0x01010101+0x01010101, assert rst at 2nd RUN cycle for 1 cycle -> next cycle state IDLE, s=0, co=0, busy=0, no done pulse. A fresh start then yields s=0x02020202.

Source files
------------

// File: rtl/adder_mp_seq_pkg.sv
// Shared definitions for the byte-serial multi-precision add/subtract sequencer.
package adder_mp_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_mp_seq_if.sv
// Request/result bundle between a requesting controller and adder_mp_seq.
interface adder_mp_seq_if #(parameter int WORDS = 4);

  logic               start;
  logic               sub;
  logic               ci;
  logic [8*WORDS-1:0] a;
  logic [8*WORDS-1:0] b;
  logic [8*WORDS-1:0] s;
  logic               co;
  logic               ovf;
  logic               busy;
  logic               done;

  modport master (
    output start, sub, ci, a, b,
    input  s, co, ovf, busy, done
  );

  modport slave (
    input  start, sub, ci, a, b,
    output s, co, ovf, busy, done
  );

endinterface

// File: rtl/adder_mp_seq_adder_8b.sv
// The shared 8-bit ripple adder that the sequencer time-multiplexes byte by byte.
module adder_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {8'd0, ci};

endmodule

// File: rtl/adder_mp_seq.sv
// Byte-serial add/subtract over WORDS bytes, LSB first, reusing one adder_8b.
module adder_mp_seq
  import adder_mp_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  adder_mp_seq_if.slave bus
);

  localparam int W     = BYTE_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       a_lat, b_lat, s_q;
  logic               carry_q, co_q, ovf_q;
  logic [BYTE_W-1:0]  a_byte, b_byte, sum_byte;
  logic               sum_co;
  logic               accept, last_byte;

  assign a_byte    = a_lat[BYTE_W*idx_q +: BYTE_W];
  assign b_byte    = b_lat[BYTE_W*idx_q +: BYTE_W];
  assign last_byte = (state_q == ST_RUN) && (idx_q == LAST_IDX);

  adder_8b u_adder (
    .a  (a_byte),
    .b  (b_byte),
    .ci (carry_q),
    .s  (sum_byte),
    .co (sum_co)
  );

  // A new request may be taken from IDLE or straight out of DONE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_byte) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, so b is inverted at capture and the carry seeded to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_lat   <= '0;
      b_lat   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_lat   <= bus.a;
        b_lat   <= bus.sub ? ~bus.b : bus.b;
        carry_q <= bus.sub | bus.ci;
        idx_q   <= '0;
      end else if (state_q == ST_RUN) begin
        s_q[BYTE_W*idx_q +: BYTE_W] <= sum_byte;
        carry_q <= sum_co;
        idx_q   <= idx_q + 1'b1;
        if (last_byte) begin
          co_q  <= sum_co;
          ovf_q <= (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) &&
                   (sum_byte[BYTE_W-1] != a_byte[BYTE_W-1]);
        end
      end
    end
  end

  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_adder_mp_seq.sv
// Randomized and directed checks of adder_mp_seq (WORDS=4) against an arithmetic reference.
module tb_adder_mp_seq;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  adder_mp_seq_if #(.WORDS(4)) bus ();

  adder_mp_seq #(.WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result defined by plain signed/unsigned 32-bit arithmetic.
  function automatic void ref_model(input logic sub, input logic ci,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] s, output logic co,
                                    output logic ovf);
    longint ua, ub, sa, sb, ures, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      ures = ua - ub;
      sres = sa - sb;
      co   = (ua >= ub);
    end else begin
      ures = ua + ub + longint'(ci);
      sres = sa + sb + longint'(ci);
      co   = (ures > 64'sd4294967295);
    end
    s   = ures[31:0];
    ovf = (sres > SMAX) || (sres < SMIN);
  endfunction

  task automatic apply_stimulus(input logic sub, input logic ci,
                                input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = sub;
    bus.ci    = ci;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] es, input logic eco,
                           input logic eovf, input int exp_busy);
    int n = 0;
    int busy_cnt = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check_output({tag, " done"}, 64'(bus.done), 64'd1);
    check_output({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check_output({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
    check_output({tag, " s"}, 64'(bus.s), 64'(es));
    check_output({tag, " co"}, 64'(bus.co), 64'(eco));
    check_output({tag, " ovf"}, 64'(bus.ovf), 64'(eovf));
  endtask

  task automatic post_check(input string tag, input logic [31:0] es);
    @(negedge clk);
    check_output({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    check_output({tag, " s_held"}, 64'(bus.s), 64'(es));
  endtask

  task automatic do_op(input string tag, input logic sub, input logic ci,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] es, input logic eco, input logic eovf);
    apply_stimulus(sub, ci, a, b);
    wait_done(tag, es, eco, eovf, 4);
    post_check(tag, es);
  endtask

  initial begin
    logic [31:0] ra, rb, es;
    logic        rsub, rci, eco, eovf;
    bit          seen_done;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.ci    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check_output("rst s", 64'(bus.s), 64'd0);
    check_output("rst co", 64'(bus.co), 64'd0);
    check_output("rst ovf", 64'(bus.ovf), 64'd0);
    check_output("rst busy", 64'(bus.busy), 64'd0);
    check_output("rst done", 64'(bus.done), 64'd0);
    rst = 1'b0;

    do_op("t1", 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
    do_op("t2a", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    do_op("t2b", 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    do_op("t3a", 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    do_op("t3b", 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
    do_op("t4", 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Start re-pulsed mid-RUN must not disturb the operation, then a back-to-back accept from DONE.
    apply_stimulus(1'b0, 1'b0, 32'h0000_0010, 32'h0000_0020);
    bus.start = 1'b1;
    bus.a     = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("t5a", 32'h0000_0030, 1'b0, 1'b0, 3);
    bus.start = 1'b1;
    bus.a     = 32'h0000_0001;
    bus.b     = 32'h0000_0001;
    @(negedge clk);
    bus.start = 1'b0;
    check_output("t5 no_idle_gap", 64'(bus.busy), 64'd1);
    wait_done("t5b", 32'h0000_0002, 1'b0, 1'b0, 4);
    post_check("t5b", 32'h0000_0002);

    // Reset in the second RUN cycle aborts the operation without a done pulse.
    apply_stimulus(1'b0, 1'b0, 32'h0101_0101, 32'h0101_0101);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("t6 busy", 64'(bus.busy), 64'd0);
    check_output("t6 done", 64'(bus.done), 64'd0);
    check_output("t6 s", 64'(bus.s), 64'd0);
    check_output("t6 co", 64'(bus.co), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    check_output("t6 no_done", 64'(seen_done), 64'd0);
    do_op("t6b", 1'b0, 1'b0, 32'h0101_0101, 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rsub = 1'($urandom_range(0, 1));
      rci  = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFF_FFFF;
        1: ra = 32'h8000_0000;
        2: rb = ra;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      ref_model(rsub, rci, ra, rb, es, eco, eovf);
      do_op($sformatf("rnd%0d", i), rsub, rci, ra, rb, es, eco, eovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
